// File: rtl/arbiter_defs.sv
// Shared definitions for the data-memory arbiter.
// FSM encoding, default starvation bound, burst-length width.
package arbiter_defs;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int LEN_W = 4;
endpackage

// File: rtl/burst_counter.sv
// DMA burst address generator and remaining-beat down-counter.
// last is high while the current beat is the final one.
module burst_counter
  import arbiter_defs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_W-1:0]      load_len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic [LEN_W-1:0] remain;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr;
      remain <= load_len;
    end else if (advance) begin
      addr   <= addr + ADDR_WIDTH'(4);
      remain <= remain - 1'b1;
    end
  end

  assign last = (remain == '0);
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single DataMemory port between the ME stage and a DMA
// burst engine; the CPU wins after STARVE_LIMIT stalled cycles.
module data_mem_arbiter
  import arbiter_defs::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_write,
  input  logic [ADDR_WIDTH-1:0] dma_address,
  input  logic [LEN_W-1:0]      dma_burst_len,
  input  logic [DATA_WIDTH-1:0] dma_write_data,
  output logic                  dma_gnt,
  output logic                  dma_beat_ack,
  output logic [DATA_WIDTH-1:0] dma_read_data,
  output logic                  dma_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  arb_state_t            state;
  logic                  dir;
  logic [7:0]            starve_cnt;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic                  last;
  logic                  cpu_access;
  logic                  cpu_slot;
  logic                  beat;
  logic                  start;

  assign cpu_access = cpu_mem_read | cpu_mem_write;
  assign start = (state == ST_IDLE) && dma_req && !cpu_access;
  assign cpu_slot = cpu_access && (starve_cnt >= 8'(STARVE_LIMIT));
  assign beat = (state == ST_BURST) && !cpu_slot;

  // Stall must act in the same cycle the beat steals the port.
  assign cpu_stall = (state == ST_BURST) && cpu_access && !cpu_slot;
  assign dma_beat_ack = beat;
  assign cpu_read_data = mem_read_data;
  assign dma_read_data = mem_read_data;

  burst_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_burst_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .advance  (beat),
    .load_addr(dma_address),
    .load_len (dma_burst_len),
    .addr     (burst_addr),
    .last     (last)
  );

  always_comb begin
    mem_read       = cpu_mem_read;
    mem_write      = cpu_mem_write;
    mem_address    = cpu_address;
    mem_write_data = cpu_write_data;
    if (beat) begin
      mem_read       = !dir;
      mem_write      = dir;
      mem_address    = burst_addr;
      mem_write_data = dma_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dir        <= 1'b0;
      starve_cnt <= '0;
      dma_gnt    <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_gnt  <= start;
      dma_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_BURST;
            dir        <= dma_write;
            starve_cnt <= '0;
          end
        end
        ST_BURST: begin
          if (cpu_stall) starve_cnt <= starve_cnt + 8'd1;
          else starve_cnt <= '0;
          if (beat && last) begin
            state    <= ST_DONE;
            dma_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
